// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-organised register array.
// Programmable wait states, byte/halfword/word lanes, two-cycle ERROR responses.
module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LP_DEPTH = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [2:0] LP_WS = 3'(WAIT_STATES);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic                  r_pend;
    logic                  r_ready;
    logic [1:0]            r_resp;
    logic                  r_rd_en;
    logic                  r_wr;
    logic [2:0]            r_size;
    logic [1:0]            r_lane;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic       w_accept;
    logic       w_err;
    logic       w_we;
    logic [3:0] w_be;
    logic       w_unused;

    // HBURST is not decoded and SEQ is treated like NONSEQ, so only HTRANS[1] matters.
    assign w_unused = &{1'b0, HBURST, HTRANS[0]};

    assign w_accept = HSEL & HREADY & HTRANS[1] & r_ready;

    assign w_err = ((HADDR >> 2) >= LP_DEPTH)
                 | (HSIZE > 3'b010)
                 | ((HSIZE == 3'b001) & HADDR[0])
                 | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

    // Completion cycle is IDLE with an OKAY access still pending; reset on that edge cancels the write.
    assign w_we = (r_state == ST_IDLE) & r_pend & r_wr & ~HRESET;

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'b000:  w_be = 4'b0001 << r_lane;
            3'b001:  w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
            r_resp  <= RESP_OKAY;
            r_rd_en <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    r_state <= ST_IDLE;
                    r_pend  <= 1'b0;
                    r_ready <= 1'b1;
                    r_resp  <= RESP_OKAY;
                    if (w_accept) begin
                        r_wr   <= HWRITE;
                        r_size <= HSIZE;
                        r_lane <= HADDR[1:0];
                        r_idx  <= HADDR[IDX_W+1:2];
                        if (w_err) begin
                            r_state <= ST_ERR1;
                            r_ready <= 1'b0;
                            r_resp  <= RESP_ERROR;
                        end else if (LP_WS != 3'd0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_WS - 3'd1;
                            r_ready <= 1'b0;
                            r_pend  <= 1'b1;
                        end else begin
                            r_pend  <= 1'b1;
                            r_rd_en <= ~HWRITE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_rd_en <= ~r_wr;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    r_state <= ST_ERR2;
                    r_ready <= 1'b1;
                    r_resp  <= RESP_ERROR;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Read data is taken combinationally so a write completing on the previous edge is already visible.
    assign HRDATA    = r_rd_en ? r_mem[r_idx] : '0;
    assign HREADYOUT = r_ready;
    assign HRESP     = r_resp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with one wait state, one with none,
// directed scenarios plus random traffic against an array-based reference model.
module tb_ahb_sram_slave;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        use0;
    logic        force_lo;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;

    logic [31:0] rd0, rd1;
    logic        ro0, ro1;
    logic [1:0]  rs0, rs1;

    logic        sel0, sel1, hro, hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int checks;
    int errors;
    logic [31:0] model [16];

    assign sel0   = sel & use0;
    assign sel1   = sel & ~use0;
    assign hro    = use0 ? ro0 : ro1;
    assign hresp  = use0 ? rs0 : rs1;
    assign hrdata = use0 ? rd0 : rd1;
    assign hready = hro & ~force_lo;

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] mask;
        if (sz == 3'd0)      mask = 32'hFF << (8 * (a % 4));
        else if (sz == 3'd1) mask = 32'hFFFF << (16 * ((a % 4) / 2));
        else                 mask = 32'hFFFF_FFFF;
        return (old & ~mask) | (wd & mask);
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        return ((a / 4) >= 256) || (sz > 3'd2) || (sz == 3'd1 && (a % 2) != 0) ||
               (sz == 3'd2 && (a % 4) != 0);
    endfunction

    // Single non-pipelined transfer; returns what the master observed in the data phase.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] rsp,
                        output logic [1:0] rsp_first, output int nlow);
        @(negedge clk);
        sel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
        hburst = 3'($urandom % 8);
        @(negedge clk);
        sel = 1'($urandom % 2); htrans = 2'($urandom % 2); hwdata = wd;
        haddr = $urandom; hwrite = 1'($urandom % 2);
        rsp_first = hresp;
        nlow = 0;
        while (hro !== 1'b1 && nlow < 20) begin
            nlow++;
            @(negedge clk);
            sel = 1'($urandom % 2); htrans = 2'($urandom % 2);
        end
        if (nlow >= 20) begin
            errors++;
            $display("FAIL xfer_timeout addr=%h HREADYOUT never returned high", a);
        end
        checks++;
        rd = hrdata; rsp = hresp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if ({ro0, rs0, rd0} !== {1'b1, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut0 got ready=%b resp=%b rdata=%h want 1 00 0", ro0, rs0, rd0);
        end
        checks++;
        if ({ro1, rs1, rd1} !== {1'b1, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_dut1 got ready=%b resp=%b rdata=%h want 1 00 0", ro1, rs1, rd1);
        end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic [1:0] rsp, rf; int nl;
        use0 = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, rd, rsp, rf, nl);
        if (nl !== 1 || rsp !== 2'b00 || rf !== 2'b00) begin
            errors++;
            $display("FAIL word_write_latency got low=%0d resp=%b/%b want 1 00/00", nl, rf, rsp);
        end
        checks++;
        xfer(32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, rf, nl);
        if (nl !== 1 || rsp !== 2'b00 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL word_read got low=%0d resp=%b rdata=%h want 1 00 deadbeef", nl, rsp, rd);
        end
        checks++;
        @(negedge clk);
        if (hrdata !== 32'h0) begin
            errors++;
            $display("FAIL rdata_after_read got %h want 0", hrdata);
        end
        checks++;
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic [1:0] rsp, rf; int nl;
        use0 = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'h0, rd, rsp, rf, nl);
        xfer(32'h11, 1'b1, 3'd0, 32'h5566_AA77, rd, rsp, rf, nl);
        xfer(32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, rf, nl);
        if (rd !== 32'h0000_AA00) begin
            errors++;
            $display("FAIL byte_lane got %h want 0000aa00", rd);
        end
        checks++;
        xfer(32'h12, 1'b1, 3'd1, 32'h1234_9999, rd, rsp, rf, nl);
        xfer(32'h13, 1'b0, 3'd0, 32'h0, rd, rsp, rf, nl);
        if (rd !== 32'h1234_AA00) begin
            errors++;
            $display("FAIL half_lane got %h want 1234aa00", rd);
        end
        checks++;
    endtask

    task automatic test_error();
        logic [31:0] rd; logic [1:0] rsp, rf; int nl;
        use0 = 1'b0;
        xfer(32'h0, 1'b1, 3'd2, 32'h0BAD_F00D, rd, rsp, rf, nl);
        xfer(32'h400, 1'b0, 3'd2, 32'h0, rd, rsp, rf, nl);
        if (rf !== 2'b01 || nl !== 1 || rsp !== 2'b01 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_oob got resp=%b/%b low=%0d rdata=%h want 01/01 1 0", rf, rsp, nl, rd);
        end
        checks++;
        xfer(32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, rsp, rf, nl);
        if (rf !== 2'b01 || nl !== 1 || rsp !== 2'b01) begin
            errors++;
            $display("FAIL err_align got resp=%b/%b low=%0d want 01/01 1", rf, rsp, nl);
        end
        checks++;
        xfer(32'h0, 1'b0, 3'd2, 32'h0, rd, rsp, rf, nl);
        if (rd !== 32'h0BAD_F00D || rsp !== 2'b00) begin
            errors++;
            $display("FAIL err_no_write got %h resp=%b want 0badf00d 00", rd, rsp);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd, pa, pwd; logic w, pw, pv; logic [2:0] sz, psz; int idx;
        use0 = 1'b1;
        @(negedge clk);
        sel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
        @(negedge clk);
        if (hro !== 1'b1 || hresp !== 2'b00) begin
            errors++;
            $display("FAIL b2b_write got ready=%b resp=%b want 1 00", hro, hresp);
        end
        checks++;
        hwdata = 32'h55; haddr = 32'h20; hwrite = 1'b0; htrans = 2'b10;
        @(negedge clk);
        if (hro !== 1'b1 || hrdata !== 32'h0000_0055) begin
            errors++;
            $display("FAIL b2b_read got ready=%b rdata=%h want 1 00000055", hro, hrdata);
        end
        checks++;
        sel = 1'b0; htrans = 2'b00;
        // Fill words 0..15, then stream random pipelined legal transfers.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) hwdata = model[i-1];
            model[i] = $urandom;
            sel = 1'b1; htrans = 2'b10; haddr = 32'(i * 4); hwrite = 1'b1; hsize = 3'd2;
        end
        @(negedge clk);
        hwdata = model[15];
        pv = 1'b0; pa = '0; pw = 1'b0; pwd = '0; psz = '0;
        for (int i = 0; i <= 60; i++) begin
            if (i > 0) @(negedge clk);
            if (pv) begin
                if (hro !== 1'b1 || hresp !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_rand_ready i=%0d got ready=%b resp=%b want 1 00", i, hro, hresp);
                end
                checks++;
                if (!pw) begin
                    if (hrdata !== model[pa / 4]) begin
                        errors++;
                        $display("FAIL b2b_rand_read i=%0d addr=%h got %h want %h", i, pa, hrdata, model[pa / 4]);
                    end
                    checks++;
                end
                hwdata = pw ? pwd : 32'($urandom);
                if (pw) model[pa / 4] = merge(model[pa / 4], pwd, pa, psz);
            end
            if (i < 60) begin
                idx = $urandom % 16;
                sz = 3'($urandom % 3);
                a = 32'(idx * 4);
                if (sz == 3'd0) a = a + 32'($urandom % 4);
                if (sz == 3'd1) a = a + 32'(2 * ($urandom % 2));
                w = 1'($urandom % 2);
                wd = $urandom;
                sel = 1'b1; htrans = {1'b1, 1'($urandom % 2)}; haddr = a; hwrite = w; hsize = sz;
                pv = 1'b1; pa = a; pw = w; pwd = wd; psz = sz;
            end else begin
                sel = 1'b0; htrans = 2'b00; pv = 1'b0;
            end
        end
    endtask

    task automatic test_no_access();
        logic [31:0] rd; logic [1:0] rsp, rf; int nl;
        use0 = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'h1122_3344, rd, rsp, rf, nl);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0 && (hro !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0)) begin
                errors++;
                $display("FAIL no_access k=%0d got ready=%b resp=%b rdata=%h want 1 00 0", k, hro, hresp, hrdata);
            end
            if (k > 0) checks++;
            sel = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
            htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
            force_lo = (k == 2);
        end
        @(negedge clk);
        if (hro !== 1'b1 || hresp !== 2'b00) begin
            errors++;
            $display("FAIL no_access_hready_lo got ready=%b resp=%b want 1 00", hro, hresp);
        end
        checks++;
        force_lo = 1'b0; sel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        if (hro !== 1'b1) begin
            errors++;
            $display("FAIL no_access_after got ready=%b want 1", hro);
        end
        checks++;
        xfer(32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, rf, nl);
        if (rd !== 32'h1122_3344) begin
            errors++;
            $display("FAIL no_access_mem got %h want 11223344", rd);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] rsp, rf; int nl;
        for (int v = 0; v < 2; v++) begin
            use0 = (v == 1);
            xfer(32'h30, 1'b1, 3'd2, 32'h0, rd, rsp, rf, nl);
            @(negedge clk);
            sel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
            @(negedge clk);
            if (hro !== (v == 1)) begin
                errors++;
                $display("FAIL rst_mid_phase v=%0d got ready=%b want %b", v, hro, (v == 1));
            end
            checks++;
            sel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            if (hro !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
                errors++;
                $display("FAIL rst_mid_out v=%0d got ready=%b resp=%b rdata=%h want 1 00 0", v, hro, hresp, hrdata);
            end
            checks++;
            xfer(32'h30, 1'b0, 3'd2, 32'h0, rd, rsp, rf, nl);
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL rst_mid_mem v=%0d got %h want 00000000", v, rd);
            end
            checks++;
        end
    endtask

    task automatic test_random(input bit w0);
        logic [31:0] rd, a, wd; logic [1:0] rsp, rf; int nl, ws, idx; logic w; logic [2:0] sz; bit e;
        use0 = w0;
        ws = w0 ? 0 : 1;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xfer(32'(i * 4), 1'b1, 3'd2, model[i], rd, rsp, rf, nl);
        end
        for (int i = 0; i < 80; i++) begin
            idx = $urandom % 16;
            a = 32'(idx * 4) + 32'($urandom % 4);
            if ($urandom % 8 == 0) begin
                a = $urandom;
                if (a < 32'h400) a = a | 32'h400;
            end
            sz = ($urandom % 6 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
            w = 1'($urandom % 2);
            wd = $urandom;
            e = is_err(a, sz);
            xfer(a, w, sz, wd, rd, rsp, rf, nl);
            if (e) begin
                if (rf !== 2'b01 || nl !== 1 || rsp !== 2'b01) begin
                    errors++;
                    $display("FAIL rand_err ws=%0d addr=%h size=%0d got resp=%b/%b low=%0d want 01/01 1", ws, a, sz, rf, rsp, nl);
                end
                checks++;
            end else begin
                if (rf !== 2'b00 || nl !== ws || rsp !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_okay ws=%0d addr=%h got resp=%b/%b low=%0d want 00/00 %0d", ws, a, rf, rsp, nl, ws);
                end
                checks++;
                if (w) begin
                    model[a / 4] = merge(model[a / 4], wd, a, sz);
                end else begin
                    if (rd !== model[a / 4]) begin
                        errors++;
                        $display("FAIL rand_read ws=%0d addr=%h got %h want %h", ws, a, rd, model[a / 4]);
                    end
                    checks++;
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst = 1'b0; sel = 1'b0; use0 = 1'b0; force_lo = 1'b0;
        haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hwdata = '0;
        test_reset();
        test_word_rw();
        test_byte_half();
        test_error();
        test_back_to_back();
        test_no_access();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
